// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared widths and helpers for the EXU write-back arbiter.
// These mirror the core-level width macros so the arbiter and its slots agree on
// default sizes when instantiated without overrides.
package e203_exu_wbck_arb_pkg;

    localparam int unsigned E203_XLEN        = 32;
    localparam int unsigned E203_RFIDX_WIDTH = 5;
    // OITF depth 2 -> one tag bit
    localparam int unsigned E203_ITAG_WIDTH  = 1;
    // Core-level default number of write-back producers (ALU + one long-pipe unit)
    localparam int unsigned E203_WBCK_NCH    = 2;

    // Channel index width, never narrower than one bit so a single-channel
    // instance still has a legal port.
    function automatic int unsigned chidx_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/e203_exu_wbck_slot.sv
// One-entry holding register for a single write-back producer.
// The slot can be filled and drained in the same cycle; a fill always wins so a
// back-to-back producer keeps the slot occupied without a bubble.
module e203_exu_wbck_slot
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int unsigned XLEN    = E203_XLEN,
    parameter int unsigned RFIDX_W = E203_RFIDX_WIDTH,
    parameter int unsigned ITAG_W  = E203_ITAG_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fill,
    input  logic               drain,
    input  logic [XLEN-1:0]    in_wdat,
    input  logic [RFIDX_W-1:0] in_rdidx,
    input  logic               in_rdwen,
    input  logic [ITAG_W-1:0]  in_itag,
    input  logic               in_longp,
    input  logic               in_err,
    output logic               full,
    output logic [XLEN-1:0]    wdat,
    output logic [RFIDX_W-1:0] rdidx,
    output logic               rdwen,
    output logic [ITAG_W-1:0]  itag,
    output logic               longp,
    output logic               err
);

    logic               full_q, full_d;
    logic [XLEN-1:0]    wdat_q;
    logic [RFIDX_W-1:0] rdidx_q;
    logic               rdwen_q;
    logic [ITAG_W-1:0]  itag_q;
    logic               longp_q;
    logic               err_q;

    // Occupancy: a refill in the drain cycle keeps the slot full
    always_comb begin
        full_d = full_q;
        if (fill) begin
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Full flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload register, loaded on every accepted result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdat_q  <= '0;
            rdidx_q <= '0;
            rdwen_q <= 1'b0;
            itag_q  <= '0;
            longp_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (fill) begin
            wdat_q  <= in_wdat;
            rdidx_q <= in_rdidx;
            rdwen_q <= in_rdwen;
            itag_q  <= in_itag;
            longp_q <= in_longp;
            err_q   <= in_err;
        end
    end

    assign full  = full_q;
    assign wdat  = wdat_q;
    assign rdidx = rdidx_q;
    assign rdwen = rdwen_q;
    assign itag  = itag_q;
    assign longp = longp_q;
    assign err   = err_q;

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: NCH buffered producers share one regfile write port and
// the commit exception port. Long-pipe results retire in OITF order and take
// priority over short-pipe results; a long-pipe result waiting for its tag never
// blocks short-pipe results in other channels.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int unsigned NCH     = E203_WBCK_NCH,
    parameter int unsigned XLEN    = E203_XLEN,
    parameter int unsigned RFIDX_W = E203_RFIDX_WIDTH,
    parameter int unsigned ITAG_W  = E203_ITAG_WIDTH,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned CHIDX_W = chidx_width(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         ch_i_valid,
    output logic [NCH-1:0]         ch_i_ready,
    input  logic [NCH*XLEN-1:0]    ch_i_wdat,
    input  logic [NCH*RFIDX_W-1:0] ch_i_rdidx,
    input  logic [NCH-1:0]         ch_i_rdwen,
    input  logic [NCH*ITAG_W-1:0]  ch_i_itag,
    input  logic [NCH-1:0]         ch_i_longp,
    input  logic [NCH-1:0]         ch_i_err,
    input  logic                   oitf_empty,
    input  logic [ITAG_W-1:0]      oitf_ret_ptr,
    output logic                   oitf_ret_ena,
    output logic                   wbck_o_valid,
    input  logic                   wbck_o_ready,
    output logic [XLEN-1:0]        wbck_o_wdat,
    output logic [RFIDX_W-1:0]     wbck_o_rdidx,
    output logic                   excp_o_valid,
    input  logic                   excp_o_ready,
    output logic [CHIDX_W-1:0]     excp_o_chidx,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [NCH-1:0]     fill;
    logic [NCH-1:0]     grant_fire;
    logic [NCH-1:0]     s_full;
    logic [NCH-1:0]     s_rdwen;
    logic [NCH-1:0]     s_longp;
    logic [NCH-1:0]     s_err;
    logic [NCH-1:0]     elig_long;
    logic [NCH-1:0]     elig_short;
    logic [XLEN-1:0]    s_wdat  [NCH];
    logic [RFIDX_W-1:0] s_rdidx [NCH];
    logic [ITAG_W-1:0]  s_itag  [NCH];

    logic               gnt_vld;
    logic [CHIDX_W-1:0] gnt_idx;
    logic [XLEN-1:0]    g_wdat;
    logic [RFIDX_W-1:0] g_rdidx;
    logic               g_rdwen;
    logic               g_longp;
    logic               g_err;
    logic               need_wb;
    logic               need_ex;
    logic               fire;

    logic [CNT_W-1:0]   stall_q, stall_d;

    assign fill       = ch_i_valid & ch_i_ready;
    assign ch_i_ready = ~s_full | grant_fire;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        e203_exu_wbck_slot #(
            .XLEN    (XLEN),
            .RFIDX_W (RFIDX_W),
            .ITAG_W  (ITAG_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .fill     (fill[g]),
            .drain    (grant_fire[g]),
            .in_wdat  (ch_i_wdat[g*XLEN +: XLEN]),
            .in_rdidx (ch_i_rdidx[g*RFIDX_W +: RFIDX_W]),
            .in_rdwen (ch_i_rdwen[g]),
            .in_itag  (ch_i_itag[g*ITAG_W +: ITAG_W]),
            .in_longp (ch_i_longp[g]),
            .in_err   (ch_i_err[g]),
            .full     (s_full[g]),
            .wdat     (s_wdat[g]),
            .rdidx    (s_rdidx[g]),
            .rdwen    (s_rdwen[g]),
            .itag     (s_itag[g]),
            .longp    (s_longp[g]),
            .err      (s_err[g])
        );

        // A long-pipe slot may only leave when it is the OITF head
        assign elig_long[g]  = s_full[g] & s_longp[g] & ~oitf_empty &
                               (s_itag[g] == oitf_ret_ptr);
        assign elig_short[g] = s_full[g] & ~s_longp[g];
    end

    // Grant: lowest eligible long-pipe slot, otherwise lowest eligible short-pipe slot
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (elig_long[k] && !gnt_vld) begin
                gnt_vld = 1'b1;
                gnt_idx = CHIDX_W'(k);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (elig_short[k] && !gnt_vld) begin
                gnt_vld = 1'b1;
                gnt_idx = CHIDX_W'(k);
            end
        end
    end

    // Payload of the granted slot; all zero when nothing is granted
    always_comb begin
        g_wdat  = '0;
        g_rdidx = '0;
        g_rdwen = 1'b0;
        g_longp = 1'b0;
        g_err   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_vld && (gnt_idx == CHIDX_W'(k))) begin
                g_wdat  = s_wdat[k];
                g_rdidx = s_rdidx[k];
                g_rdwen = s_rdwen[k];
                g_longp = s_longp[k];
                g_err   = s_err[k];
            end
        end
    end

    // Output handshake: when both ports are needed neither valid is raised until
    // the other side is ready, so the pair commits atomically.
    always_comb begin
        need_wb      = gnt_vld & g_rdwen & ~g_err;
        need_ex      = gnt_vld & g_err;
        wbck_o_valid = need_wb & (~need_ex | excp_o_ready);
        excp_o_valid = need_ex & (~need_wb | wbck_o_ready);
        fire         = gnt_vld & (~need_wb | wbck_o_ready) & (~need_ex | excp_o_ready);
        oitf_ret_ena = fire & g_longp;
        wbck_o_wdat  = g_wdat;
        wbck_o_rdidx = g_rdidx;
        excp_o_chidx = gnt_idx;
        grant_fire   = '0;
        for (int k = 0; k < NCH; k++) begin
            grant_fire[k] = fire & (gnt_idx == CHIDX_W'(k));
        end
    end

    // Stall counter next state: saturating count of cycles with work but no retirement
    always_comb begin
        stall_d = stall_q;
        if ((|s_full) && !fire && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed bench for the write-back arbiter. A slot-level model predicts every
// output each cycle; literal checks pin the model to hand-worked scenarios.
module tb_e203_exu_wbck_arb;

    localparam int NCH     = 2;
    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int ITAG_W  = 2;
    localparam int CNT_W   = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NCH-1:0]         ch_i_valid;
    logic [NCH-1:0]         ch_i_ready;
    logic [NCH*XLEN-1:0]    ch_i_wdat;
    logic [NCH*RFIDX_W-1:0] ch_i_rdidx;
    logic [NCH-1:0]         ch_i_rdwen;
    logic [NCH*ITAG_W-1:0]  ch_i_itag;
    logic [NCH-1:0]         ch_i_longp;
    logic [NCH-1:0]         ch_i_err;
    logic                   oitf_empty;
    logic [ITAG_W-1:0]      oitf_ret_ptr;
    logic                   oitf_ret_ena;
    logic                   wbck_o_valid;
    logic                   wbck_o_ready;
    logic [XLEN-1:0]        wbck_o_wdat;
    logic [RFIDX_W-1:0]     wbck_o_rdidx;
    logic                   excp_o_valid;
    logic                   excp_o_ready;
    logic [0:0]             excp_o_chidx;
    logic [CNT_W-1:0]       stall_cnt;

    e203_exu_wbck_arb #(
        .NCH     (NCH),
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .ITAG_W  (ITAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_i_valid   (ch_i_valid),
        .ch_i_ready   (ch_i_ready),
        .ch_i_wdat    (ch_i_wdat),
        .ch_i_rdidx   (ch_i_rdidx),
        .ch_i_rdwen   (ch_i_rdwen),
        .ch_i_itag    (ch_i_itag),
        .ch_i_longp   (ch_i_longp),
        .ch_i_err     (ch_i_err),
        .oitf_empty   (oitf_empty),
        .oitf_ret_ptr (oitf_ret_ptr),
        .oitf_ret_ena (oitf_ret_ena),
        .wbck_o_valid (wbck_o_valid),
        .wbck_o_ready (wbck_o_ready),
        .wbck_o_wdat  (wbck_o_wdat),
        .wbck_o_rdidx (wbck_o_rdidx),
        .excp_o_valid (excp_o_valid),
        .excp_o_ready (excp_o_ready),
        .excp_o_chidx (excp_o_chidx),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic             m_full  [NCH];
    logic [XLEN-1:0]  m_wdat  [NCH];
    logic [4:0]       m_rdidx [NCH];
    logic             m_rdwen [NCH];
    logic [1:0]       m_itag  [NCH];
    logic             m_longp [NCH];
    logic             m_err   [NCH];
    logic [CNT_W-1:0] m_cnt;
    logic [NCH-1:0]   exp_rdy;
    logic             exp_fire;
    int               exp_g;

    // Predict and compare every output at the falling edge
    always @(negedge clk) begin
        int  g;
        logic nwb, nex, ev_wb, ev_ex, ret;
        if (!rst_n) begin
            chk("rst_ready", ch_i_ready, 2'b11);
            chk("rst_wbck_valid", wbck_o_valid, 0);
            chk("rst_excp_valid", excp_o_valid, 0);
            chk("rst_ret_ena", oitf_ret_ena, 0);
            chk("rst_wdat", wbck_o_wdat, 0);
            chk("rst_stall", stall_cnt, 0);
            exp_rdy  = '1;
            exp_fire = 1'b0;
            exp_g    = -1;
        end else begin
            g = -1;
            for (int k = 0; k < NCH; k++)
                if (g < 0 && m_full[k] && m_longp[k] && !oitf_empty && m_itag[k] == oitf_ret_ptr)
                    g = k;
            for (int k = 0; k < NCH; k++)
                if (g < 0 && m_full[k] && !m_longp[k])
                    g = k;
            nwb = (g >= 0) && m_rdwen[g] && !m_err[g];
            nex = (g >= 0) && m_err[g];
            ev_wb = nwb && (!nex || excp_o_ready);
            ev_ex = nex && (!nwb || wbck_o_ready);
            exp_fire = (g >= 0) && (!nwb || wbck_o_ready) && (!nex || excp_o_ready);
            ret = exp_fire && m_longp[g];
            exp_g = g;
            for (int k = 0; k < NCH; k++)
                exp_rdy[k] = !m_full[k] || (exp_fire && g == k);
            chk("ch_i_ready", ch_i_ready, exp_rdy);
            chk("wbck_o_valid", wbck_o_valid, ev_wb);
            chk("excp_o_valid", excp_o_valid, ev_ex);
            chk("oitf_ret_ena", oitf_ret_ena, ret);
            chk("stall_cnt", stall_cnt, m_cnt);
            if (g < 0) begin
                chk("idle_wdat", wbck_o_wdat, 0);
                chk("idle_rdidx", wbck_o_rdidx, 0);
            end
            if (nwb) begin
                chk("wbck_o_wdat", wbck_o_wdat, m_wdat[g]);
                chk("wbck_o_rdidx", wbck_o_rdidx, m_rdidx[g]);
            end
            if (ev_ex) chk("excp_o_chidx", excp_o_chidx, g);
        end
    end

    // Model state update: retire the predicted winner, accept new results
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) m_full[k] <= 1'b0;
            m_cnt <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ch_i_valid[k] && exp_rdy[k]) begin
                    m_full[k]  <= 1'b1;
                    m_wdat[k]  <= ch_i_wdat[k*XLEN +: XLEN];
                    m_rdidx[k] <= ch_i_rdidx[k*RFIDX_W +: RFIDX_W];
                    m_rdwen[k] <= ch_i_rdwen[k];
                    m_itag[k]  <= ch_i_itag[k*ITAG_W +: ITAG_W];
                    m_longp[k] <= ch_i_longp[k];
                    m_err[k]   <= ch_i_err[k];
                end else if (exp_fire && exp_g == k) begin
                    m_full[k] <= 1'b0;
                end
            end
            if ((m_full[0] || m_full[1]) && !exp_fire && m_cnt != 4'hF)
                m_cnt <= m_cnt + 4'd1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [31:0] d, input logic [4:0] r,
                         input logic we, input logic [1:0] tg, input logic lp,
                         input logic er);
        ch_i_valid[k]                   = 1'b1;
        ch_i_wdat[k*XLEN +: XLEN]       = d;
        ch_i_rdidx[k*RFIDX_W +: RFIDX_W] = r;
        ch_i_rdwen[k]                   = we;
        ch_i_itag[k*ITAG_W +: ITAG_W]   = tg;
        ch_i_longp[k]                   = lp;
        ch_i_err[k]                     = er;
    endtask

    task automatic idle();
        ch_i_valid = '0;
    endtask

    initial begin
        rst_n        = 1'b0;
        ch_i_valid   = '0;
        ch_i_wdat    = '0;
        ch_i_rdidx   = '0;
        ch_i_rdwen   = '0;
        ch_i_itag    = '0;
        ch_i_longp   = '0;
        ch_i_err     = '0;
        oitf_empty   = 1'b1;
        oitf_ret_ptr = '0;
        wbck_o_ready = 1'b1;
        excp_o_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Single short result
        step();
        drive(0, 32'h1234, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t1_valid", wbck_o_valid, 1);
        chk("t1_wdat", wbck_o_wdat, 32'h1234);
        chk("t1_rdidx", wbck_o_rdidx, 5);
        chk("t1_ret", oitf_ret_ena, 0);
        step();

        // Long-pipe tag mismatch holds while short result passes
        oitf_empty   = 1'b0;
        oitf_ret_ptr = 2'd1;
        drive(1, 32'hAAAA, 5'd7, 1'b1, 2'd2, 1'b1, 1'b0);
        drive(0, 32'h5555, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t2_short_wdat", wbck_o_wdat, 32'h5555);
        step();
        @(negedge clk);
        chk("t2_hold_ready", ch_i_ready, 2'b01);
        chk("t2_hold_valid", wbck_o_valid, 0);
        step();
        @(negedge clk);
        chk("t2_stall1", stall_cnt, 1);
        step();
        oitf_ret_ptr = 2'd2;
        @(negedge clk);
        chk("t2_stall2", stall_cnt, 2);
        chk("t2_long_wdat", wbck_o_wdat, 32'hAAAA);
        chk("t2_long_ret", oitf_ret_ena, 1);
        step();

        // Long beats short when both eligible
        oitf_ret_ptr = 2'd3;
        drive(0, 32'hC0, 5'd1, 1'b1, 2'd0, 1'b0, 1'b0);
        drive(1, 32'hC1, 5'd2, 1'b1, 2'd3, 1'b1, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t3_first", wbck_o_wdat, 32'hC1);
        chk("t3_first_ret", oitf_ret_ena, 1);
        step();
        @(negedge clk);
        chk("t3_second", wbck_o_wdat, 32'hC0);
        chk("t3_second_ret", oitf_ret_ena, 0);
        step();

        // Error routing
        excp_o_ready = 1'b0;
        drive(0, 32'hE, 5'd4, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("t4_wb_valid", wbck_o_valid, 0);
        chk("t4_ex_valid", excp_o_valid, 1);
        chk("t4_chidx", excp_o_chidx, 0);
        step();
        @(negedge clk);
        chk("t4_held", ch_i_ready, 2'b10);
        step();
        excp_o_ready = 1'b1;
        @(negedge clk);
        chk("t4_ex_valid2", excp_o_valid, 1);
        step();
        @(negedge clk);
        chk("t4_empty", ch_i_ready, 2'b11);
        drive(1, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("t4_chidx1", excp_o_chidx, 1);
        step();
        drive(0, 32'h9, 5'd9, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t4_nop_valid", wbck_o_valid | excp_o_valid, 0);
        chk("t4_nop_ready", ch_i_ready, 2'b11);
        step();

        // Streaming after a fresh reset, then a 3-cycle downstream stall
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(0, 32'h100, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 32'h100 + i, 5'(i), 1'b1, 2'd0, 1'b0, 1'b0);
            @(negedge clk);
            chk("t5_stream_wdat", wbck_o_wdat, 32'h100 + i - 1);
            chk("t5_stream_ready", ch_i_ready[0], 1);
            step();
        end
        wbck_o_ready = 1'b0;
        drive(0, 32'h200, 5'd8, 1'b1, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_block_ready", ch_i_ready[0], 0);
        step();
        step();
        step();
        wbck_o_ready = 1'b1;
        idle();
        @(negedge clk);
        chk("t5_stall3", stall_cnt, 3);
        chk("t5_resume", wbck_o_wdat, 32'h104);
        step();

        // Reset while slots are full
        oitf_ret_ptr = 2'd1;
        wbck_o_ready = 1'b0;
        drive(1, 32'h66, 5'd6, 1'b1, 2'd0, 1'b1, 1'b0);
        drive(0, 32'h65, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("t6_full", ch_i_ready, 2'b00);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", ch_i_ready, 2'b11);
        chk("t6_rst_ret", oitf_ret_ena, 0);
        step();
        rst_n = 1'b1;
        wbck_o_ready = 1'b1;
        @(negedge clk);
        chk("t6_after", wbck_o_valid, 0);

        // Saturation: long result blocked by an empty OITF
        step();
        oitf_empty   = 1'b1;
        oitf_ret_ptr = 2'd0;
        drive(1, 32'h77, 5'd9, 1'b1, 2'd0, 1'b1, 1'b0);
        step();
        idle();
        repeat (20) step();
        @(negedge clk);
        chk("t7_sat", stall_cnt, 4'hF);
        chk("t7_blocked", wbck_o_valid, 0);
        step();
        oitf_empty = 1'b0;
        @(negedge clk);
        chk("t7_fire_wdat", wbck_o_wdat, 32'h77);
        chk("t7_fire_ret", oitf_ret_ena, 1);
        chk("t7_sat_hold", stall_cnt, 4'hF);
        step();
        @(negedge clk);
        chk("t7_empty", ch_i_ready, 2'b11);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
